// File: rtl/rom_pkg.sv
// rom_pkg: memory-map constants and range helper shared by ROM, RAM and the bus decoder
package rom_pkg;
    localparam logic [31:0] ROM_BASE = 32'h0800_0000;
    localparam logic [31:0] ROM_SIZE = 32'h0010_0000;
    localparam int          WORD_W   = 32;

    // 33-bit compare so that base + size cannot wrap at the top of the address space
    function automatic logic in_window(input logic [31:0] a, input logic [31:0] base,
                                       input logic [31:0] size);
        return ({1'b0, a} >= {1'b0, base}) && ({1'b0, a} < ({1'b0, base} + {1'b0, size}));
    endfunction
endpackage

// File: rtl/rom_if.sv
// rom_if: word-wide memory access bus between a fetch/load master and the ROM
interface rom_if;
    import rom_pkg::*;
    logic              write_enable;
    logic [31:0]       address;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;

    modport master (output write_enable, address, data_in, input data_out);
    modport slave  (input write_enable, address, data_in, output data_out);
endinterface

// File: rtl/rom_sp_bram.sv
// sp_bram: generic single-port read-first block RAM with registered read data
module sp_bram #(
  parameter int    DEPTH     = 1024,
  parameter int    WIDTH     = 32,
  parameter string INIT_FILE = "",
  localparam int   AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
    rdata_q <= mem[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/rom.sv
// rom: program memory window with address decode, range gating and data_out reset
module rom
    import rom_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = ROM_BASE,
    parameter logic [31:0] SIZE_BYTES = ROM_SIZE,
    parameter string       INIT_FILE  = ""
) (
    input logic  clock,
    input logic  reset,
    rom_if.slave bus
);
    localparam int DEPTH = int'(SIZE_BYTES / 4);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              hit;
    logic              we;
    logic [AW-1:0]     idx;
    logic              hit_d, hit_q;
    logic [WORD_W-1:0] rdata;

    // Decode: the range check gates both ports, so a wrapped index outside the window is harmless
    always_comb begin
        hit   = in_window(bus.address, BASE_ADDR, SIZE_BYTES);
        idx   = bus.address[AW+1:2] - BASE_ADDR[AW+1:2];
        we    = bus.write_enable && hit && !reset;
        hit_d = hit && !reset;
    end

    // Remember whether the word read this edge should be shown or forced to zero
    always_ff @(posedge clock) begin
        if (reset) hit_q <= 1'b0;
        else       hit_q <= hit_d;
    end

    sp_bram #(
        .DEPTH     (DEPTH),
        .WIDTH     (WORD_W),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk_i   (clock),
        .we_i    (we),
        .addr_i  (idx),
        .wdata_i (bus.data_in),
        .rdata_o (rdata)
    );

    assign bus.data_out = hit_q ? rdata : '0;
endmodule

// File: tb/tb_rom.sv
// tb_rom: directed vector bench for the ROM window
module tb_rom;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    rom_if bus ();

    rom u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t v[16];

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (bus.data_out !== exp) begin
            errors++;
            $display("FAIL %s: data_out=%h expected=%h", name, bus.data_out, exp);
        end
    endtask

    task automatic step(input logic we, input logic [31:0] addr, input logic [31:0] din);
        bus.write_enable = we;
        bus.address      = addr;
        bus.data_in      = din;
        @(posedge clock);
        #1;
    endtask

    initial begin
        v[0]  = '{"wr_first",      1'b1, 32'h0800_0000, 32'h0123_4567, 1'b0, 32'h0};
        v[1]  = '{"rd_first",      1'b0, 32'h0800_0000, 32'h1111_1111, 1'b1, 32'h0123_4567};
        v[2]  = '{"wr_above",      1'b1, 32'h0810_0000, 32'hFEDC_BA90, 1'b1, 32'h0};
        v[3]  = '{"rd_above",      1'b0, 32'h0810_0000, 32'h0,         1'b1, 32'h0};
        v[4]  = '{"rd_first_kept", 1'b0, 32'h0800_0000, 32'h0,         1'b1, 32'h0123_4567};
        v[5]  = '{"wr_last",       1'b1, 32'h080F_FFFC, 32'h89AB_CDEF, 1'b0, 32'h0};
        v[6]  = '{"rd_last",       1'b0, 32'h080F_FFFC, 32'h0,         1'b1, 32'h89AB_CDEF};
        v[7]  = '{"rd_first_ok",   1'b0, 32'h0800_0000, 32'h0,         1'b1, 32'h0123_4567};
        v[8]  = '{"wr_below",      1'b1, 32'h07FF_FFFC, 32'hDEAD_BEEF, 1'b1, 32'h0};
        v[9]  = '{"rd_below",      1'b0, 32'h07FF_FFFC, 32'h0,         1'b1, 32'h0};
        v[10] = '{"wr_unaligned",  1'b1, 32'h0800_0003, 32'hAAAA_5555, 1'b1, 32'h0123_4567};
        v[11] = '{"rd_unaligned",  1'b0, 32'h0800_0000, 32'h0,         1'b1, 32'hAAAA_5555};
        v[12] = '{"wr_same_edge",  1'b1, 32'h0800_0000, 32'h2222_2222, 1'b1, 32'hAAAA_5555};
        v[13] = '{"rd_after_same", 1'b0, 32'h0800_0000, 32'h3333_3333, 1'b1, 32'h2222_2222};
        v[14] = '{"rd_low_bits",   1'b0, 32'h0800_0002, 32'h0,         1'b1, 32'h2222_2222};
        v[15] = '{"rd_top_wrap",   1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 32'h0};

        reset = 1'b1;
        bus.write_enable = 1'b0;
        bus.address      = 32'h0800_0000;
        bus.data_in      = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_state", 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(v[i].we, v[i].addr, v[i].din);
            if (v[i].chk) check(v[i].name, v[i].exp);
        end

        // Reset while reading a valid word, with a write attempted that must be blocked
        reset = 1'b1;
        step(1'b1, 32'h0800_0000, 32'h4444_4444);
        check("reset_clears_out", 32'h0);
        step(1'b0, 32'h0800_0000, 32'h0);
        check("reset_held", 32'h0);
        reset = 1'b0;
        step(1'b0, 32'h0800_0000, 32'h0);
        check("retained_first", 32'h2222_2222);
        step(1'b0, 32'h080F_FFFC, 32'h0);
        check("retained_last", 32'h89AB_CDEF);

        // Out-of-range read right after a valid one drops to zero in one cycle
        step(1'b0, 32'h0810_0000, 32'h0);
        check("oor_after_valid", 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
